// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared state encoding and direction constants for the frame receiver
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam string DIR_LEFT  = "LEFT";
  localparam string DIR_RIGHT = "RIGHT";

endpackage

// File: rtl/sipo_shift_reg.sv
// rtl/sipo_shift_reg.sv - serial-in parallel-out data shift register
module sipo_shift_reg
  import serial_frame_pkg::*;
#(
  parameter int    SHIFT_WIDTH     = 8,
  parameter string SHIFT_DIRECTION = DIR_LEFT
) (
  input  logic                   clock,
  input  logic                   sclr,
  input  logic                   shift_en,
  input  logic                   shiftin,
  output logic [SHIFT_WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (sclr) begin
      q <= '0;
    end else if (shift_en) begin
      // LEFT is MSB first, so the newest bit lands at bit 0.
      if (SHIFT_DIRECTION == DIR_RIGHT) begin
        q <= {shiftin, q[SHIFT_WIDTH-1:1]};
      end else begin
        q <= {q[SHIFT_WIDTH-2:0], shiftin};
      end
    end
  end

endmodule

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - framed serial receiver with parity, stop check and valid/ready output
module serial_frame_receiver
  import serial_frame_pkg::*;
#(
  parameter int    SHIFT_WIDTH     = 8,
  parameter string SHIFT_DIRECTION = DIR_LEFT,
  parameter int    PARITY_EN       = 1
) (
  input  logic                   clock,
  input  logic                   sclr,
  input  logic                   enable,
  input  logic                   serial_in,
  input  logic                   data_ready,
  output logic [SHIFT_WIDTH-1:0] data_out,
  output logic                   data_valid,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   overflow
);

  localparam int              CW       = $clog2(SHIFT_WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(SHIFT_WIDTH - 1);

  rx_state_t              state;
  logic [CW-1:0]          bit_cnt;
  logic                   acc;
  logic                   par_bad;
  logic [SHIFT_WIDTH-1:0] shift_q;

  sipo_shift_reg #(
    .SHIFT_WIDTH    (SHIFT_WIDTH),
    .SHIFT_DIRECTION(SHIFT_DIRECTION)
  ) u_shift (
    .clock   (clock),
    .sclr    (sclr),
    .shift_en(enable && (state == DATA)),
    .shiftin (serial_in),
    .q       (shift_q)
  );

  always_ff @(posedge clock) begin
    if (sclr) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      acc        <= 1'b0;
      par_bad    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
      if (enable) begin
        case (state)
          IDLE: begin
            if (serial_in) begin
              state   <= DATA;
              bit_cnt <= '0;
              acc     <= 1'b0;
              par_bad <= 1'b0;
            end
          end
          DATA: begin
            acc <= acc ^ serial_in;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          PARITY: begin
            par_bad <= acc ^ serial_in;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            // A parity failure masks any stop-bit problem on the same frame.
            if (par_bad) begin
              parity_err <= 1'b1;
            end else if (serial_in) begin
              frame_err <= 1'b1;
            end else begin
              data_out   <= shift_q;
              data_valid <= 1'b1;
              if (data_valid && !data_ready) begin
                overflow <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - scoreboard bench for LEFT and RIGHT receiver instances
module tb_serial_frame_receiver;

  logic       clock = 1'b0;
  logic       sclr, enable, serial_in, data_ready;
  logic [7:0] dout_l, dout_r;
  logic       dv_l, dv_r, pe_l, pe_r, fe_l, fe_r, ov_l, ov_r;

  always #5 clock = ~clock;

  serial_frame_receiver #(.SHIFT_WIDTH(8), .SHIFT_DIRECTION("LEFT"), .PARITY_EN(1)) dut_l (
    .clock(clock), .sclr(sclr), .enable(enable), .serial_in(serial_in), .data_ready(data_ready),
    .data_out(dout_l), .data_valid(dv_l), .parity_err(pe_l), .frame_err(fe_l), .overflow(ov_l));

  serial_frame_receiver #(.SHIFT_WIDTH(8), .SHIFT_DIRECTION("RIGHT"), .PARITY_EN(1)) dut_r (
    .clock(clock), .sclr(sclr), .enable(enable), .serial_in(serial_in), .data_ready(data_ready),
    .data_out(dout_r), .data_valid(dv_r), .parity_err(pe_r), .frame_err(fe_r), .overflow(ov_r));

  typedef struct {
    logic [7:0] wl;
    logic [7:0] wr;
  } good_t;

  good_t good_q[$];
  int    err_q[$];
  int    checks = 0;
  int    errors = 0;
  int    ready_mode = 0;
  bit    exp_ov = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // LSB-first receiver sees the MSB-first transmitted word bit-reversed.
  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r = 8'h00;
    for (int i = 0; i < 8; i++) r = r + 8'((int'(w[7-i])) << i);
    return r;
  endfunction

  task automatic put_bit(input logic b, input int pre, input int post);
    repeat (pre) begin
      enable = 1'b0; serial_in = 1'($urandom_range(0, 1)); tick();
    end
    enable = 1'b1; serial_in = b; tick();
    enable = 1'b0;
    repeat (post) begin
      serial_in = 1'($urandom_range(0, 1)); tick();
    end
  endtask

  // mode 0: contiguous, 1: enable toggles 1/0, 2: random enable gaps
  task automatic send_frame(input logic [7:0] w, input bit bad_par, input bit stop, input int mode);
    logic  bits [11];
    good_t g;
    if (bad_par) err_q.push_back(1);
    else if (stop) err_q.push_back(2);
    else begin
      g.wl = w;
      g.wr = rev8(w);
      if (ready_mode == 0 && good_q.size() > 0) begin
        good_q[good_q.size()-1] = g;
        exp_ov = 1'b1;
      end else begin
        good_q.push_back(g);
      end
    end
    bits[0] = 1'b1;
    for (int i = 0; i < 8; i++) bits[i+1] = w[7-i];
    bits[9]  = (^w) ^ bad_par;
    bits[10] = stop;
    for (int i = 0; i < 11; i++)
      put_bit(bits[i], (mode == 2 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0,
              (mode == 1) ? 1 : 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((good_q.size() + err_q.size()) != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_queues", 32'(good_q.size() + err_q.size()), 32'd0);
  endtask

  initial begin
    int pend = 0;
    data_ready = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      case (ready_mode)
        0: data_ready = 1'b0;
        2: data_ready = 1'b1;
        default: begin
          if (dv_l) pend++; else pend = 0;
          data_ready = (pend >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
        end
      endcase
    end
  end

  initial begin
    good_t g;
    int    e;
    forever begin
      @(negedge clock);
      if (pe_l || fe_l || pe_r || fe_r) begin
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_err actual pe=%0b fe=%0b required none", pe_l, fe_l);
        end else begin
          e = err_q.pop_front();
          chk("err_pulses", 32'({pe_l, fe_l, pe_r, fe_r}), (e == 1) ? 32'hA : 32'h5);
        end
      end
      if (!sclr && dv_l && data_ready) begin
        if (good_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word actual=%0h required none", dout_l);
        end else begin
          g = good_q.pop_front();
          chk("word_left", 32'(dout_l), 32'(g.wl));
          chk("word_right", 32'(dout_r), 32'(g.wr));
          chk("valid_right", 32'(dv_r), 32'd1);
        end
      end
    end
  end

  initial begin
    sclr = 1'b1; enable = 1'b1; serial_in = 1'b1;
    tick();
    chk("rst_dout", 32'({dout_l, dout_r}), 32'd0);
    chk("rst_flags", 32'({dv_l, pe_l, fe_l, ov_l, dv_r, pe_r, fe_r, ov_r}), 32'd0);
    sclr = 1'b0; enable = 1'b0;

    ready_mode = 0;
    send_frame(8'hAA, 1'b0, 1'b0, 0);
    chk("aa_valid", 32'(dv_l), 32'd1);
    chk("aa_left", 32'(dout_l), 32'hAA);
    chk("aa_right", 32'(dout_r), 32'h55);
    chk("aa_no_pulse", 32'({pe_l, fe_l}), 32'd0);
    ready_mode = 1;
    drain();

    send_frame(8'h55, 1'b0, 1'b0, 0);
    drain();

    ready_mode = 0;
    send_frame(8'hAA, 1'b0, 1'b0, 1);
    chk("toggle_valid", 32'(dv_l), 32'd1);
    chk("toggle_left", 32'(dout_l), 32'hAA);
    ready_mode = 1;
    drain();

    send_frame(8'hAA, 1'b1, 1'b0, 0);
    chk("perr_valid", 32'(dv_l), 32'd0);
    send_frame(8'($urandom), 1'b1, 1'b1, 2);
    drain();

    ready_mode = 0;
    send_frame(8'h5A, 1'b0, 1'b0, 0);
    send_frame(8'h81, 1'b0, 1'b1, 0);
    chk("ferr_hold_data", 32'(dout_l), 32'h5A);
    chk("ferr_hold_valid", 32'(dv_l), 32'd1);
    ready_mode = 1;
    drain();

    ready_mode = 0;
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    chk("ovf_first", 32'(ov_l), 32'd0);
    send_frame(8'hC3, 1'b0, 1'b0, 0);
    chk("ovf_data", 32'(dout_l), 32'hC3);
    chk("ovf_valid", 32'(dv_l), 32'd1);
    chk("ovf_flag", 32'({ov_l, ov_r}), exp_ov ? 32'd3 : 32'd0);
    ready_mode = 2;
    tick();
    ready_mode = 0;
    tick();
    chk("ovf_consumed", 32'(dv_l), 32'd0);
    chk("ovf_sticky", 32'(ov_l), 32'd1);
    drain();
    sclr = 1'b1; tick(); sclr = 1'b0;
    exp_ov = 1'b0;
    chk("ovf_cleared", 32'({ov_l, ov_r}), 32'd0);

    ready_mode = 1;
    put_bit(1'b1, 0, 0);
    for (int i = 0; i < 4; i++) put_bit(1'($urandom_range(0, 1)), 0, 0);
    sclr = 1'b1; tick(); sclr = 1'b0;
    send_frame(8'h0F, 1'b0, 1'b0, 0);
    drain();

    for (int f = 0; f < 40; f++) begin
      int kind;
      repeat ($urandom_range(0, 3)) begin
        enable = 1'($urandom_range(0, 1));
        serial_in = enable ? 1'b0 : 1'($urandom_range(0, 1));
        tick();
      end
      kind = int'($urandom_range(0, 9));
      send_frame(8'($urandom), kind == 0, (kind == 1) || (kind == 0 && $urandom_range(0, 1) == 1), 2);
    end
    drain();
    chk("final_overflow", 32'({ov_l, ov_r}), exp_ov ? 32'd3 : 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
